// File: rtl/mem_stage.sv
// MEM stage of the 5-stage MIPS pipeline: registers the EX->MEM bus, waits for
// the data-SRAM load response, aligns/extends load data and drives MEM->WB and MEM->ID.
module mem_stage #(
  parameter int STALL_WD     = 6,
  parameter int EX_TO_MEM_WD = 79,
  parameter int MEM_TO_WB_WD = 70
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_WD-1:0]     stall,
  input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  input  logic [31:0]             data_sram_rdata,
  input  logic                    data_sram_rvalid,
  output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic [37:0]             mem_to_id,
  output logic                    stallreq_from_mem
);

  localparam logic STOP = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus_r;
  logic [31:0]             rdata_buf_r;
  state_t                  state_r;
  state_t                  state_next_s;

  logic [31:0] mem_pc_s;
  logic [2:0]  load_op_s;
  logic        data_ram_en_s;
  logic [3:0]  data_ram_wen_s;
  logic        sel_rf_res_s;
  logic        rf_we_s;
  logic [4:0]  rf_waddr_s;
  logic [31:0] ex_result_s;
  logic        is_load_s;
  logic        bubble_s;
  logic        advance_s;
  logic        wait_active_s;
  logic        capture_s;
  logic        stallreq_s;
  logic [31:0] load_raw_s;
  logic [31:0] rf_wdata_s;

  // Little-endian lane select with sign/zero extension; LW and the unused codes pass the word.
  function automatic logic [31:0] align_load(input logic [2:0] op, input logic [1:0] addr,
                                             input logic [31:0] raw);
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] res_v;
    case (addr)
      2'd0:    byte_v = raw[7:0];
      2'd1:    byte_v = raw[15:8];
      2'd2:    byte_v = raw[23:16];
      2'd3:    byte_v = raw[31:24];
      default: byte_v = raw[7:0];
    endcase
    half_v = addr[1] ? raw[31:16] : raw[15:0];
    case (op)
      3'b001:  res_v = {{24{byte_v[7]}}, byte_v};
      3'b010:  res_v = {24'h000000, byte_v};
      3'b011:  res_v = {{16{half_v[15]}}, half_v};
      3'b100:  res_v = {16'h0000, half_v};
      default: res_v = raw;
    endcase
    return res_v;
  endfunction

  assign mem_pc_s       = ex_to_mem_bus_r[78:47];
  assign load_op_s      = ex_to_mem_bus_r[46:44];
  assign data_ram_en_s  = ex_to_mem_bus_r[43];
  assign data_ram_wen_s = ex_to_mem_bus_r[42:39];
  assign sel_rf_res_s   = ex_to_mem_bus_r[38];
  assign rf_we_s        = ex_to_mem_bus_r[37];
  assign rf_waddr_s     = ex_to_mem_bus_r[36:32];
  assign ex_result_s    = ex_to_mem_bus_r[31:0];

  assign is_load_s = data_ram_en_s && (data_ram_wen_s == 4'b0000) && (load_op_s != 3'b000);
  assign bubble_s  = (stall[3] == STOP) && (stall[4] != STOP);
  assign advance_s = (stall[3] != STOP);

  // Input register: reset, bubble, load or hold.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_to_mem_bus_r <= {EX_TO_MEM_WD{1'b0}};
    end else if (bubble_s) begin
      ex_to_mem_bus_r <= {EX_TO_MEM_WD{1'b0}};
    end else if (advance_s) begin
      ex_to_mem_bus_r <= ex_to_mem_bus;
    end else begin
      ex_to_mem_bus_r <= ex_to_mem_bus_r;
    end
  end

  // A load sitting in IDLE is already waiting on its first MEM cycle.
  always_comb begin
    wait_active_s = 1'b0;
    case (state_r)
      IDLE:    wait_active_s = is_load_s;
      WAIT:    wait_active_s = 1'b1;
      DONE:    wait_active_s = 1'b0;
      default: wait_active_s = 1'b0;
    endcase
  end

  // Next-state and stall request.
  always_comb begin
    state_next_s = state_r;
    capture_s    = 1'b0;
    stallreq_s   = 1'b0;
    if (wait_active_s) begin
      if (data_sram_rvalid) begin
        capture_s    = 1'b1;
        state_next_s = advance_s ? IDLE : DONE;
      end else begin
        stallreq_s   = 1'b1;
        state_next_s = advance_s ? IDLE : WAIT;
      end
    end else if (state_r == DONE) begin
      state_next_s = advance_s ? IDLE : DONE;
    end else begin
      state_next_s = IDLE;
    end
    // A bubble discards whatever the register held, including a pending load.
    if (bubble_s) begin
      state_next_s = IDLE;
    end else begin
      state_next_s = state_next_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Response buffer, written only by the response to a pending load.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata_buf_r <= 32'h0000_0000;
    end else if (capture_s) begin
      rdata_buf_r <= data_sram_rdata;
    end else begin
      rdata_buf_r <= rdata_buf_r;
    end
  end

  assign load_raw_s = (state_r == DONE) ? rdata_buf_r : data_sram_rdata;
  assign rf_wdata_s = sel_rf_res_s ? align_load(load_op_s, ex_result_s[1:0], load_raw_s)
                                   : ex_result_s;

  assign mem_to_wb_bus     = {mem_pc_s, rf_we_s, rf_waddr_s, rf_wdata_s};
  assign mem_to_id         = {rf_we_s, rf_waddr_s, rf_wdata_s};
  assign stallreq_from_mem = stallreq_s;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: table of single-cycle accesses plus hand-written
// sequences for late responses, downstream holds, bubbles and reset in WAIT.
module tb_mem_stage;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic [78:0] ex_to_mem_bus;
  logic [31:0] data_sram_rdata;
  logic        data_sram_rvalid;
  logic [69:0] mem_to_wb_bus;
  logic [37:0] mem_to_id;
  logic        stallreq_from_mem;

  int checks;
  int errors;

  typedef struct {
    logic        en;
    logic [3:0]  wen;
    logic [2:0]  op;
    logic        sel;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        rvalid;
    logic [31:0] exp_wdata;
    logic        exp_stallreq;
  } vec_t;

  vec_t vecs[11];

  mem_stage dut (
    .clk               (clk),
    .rst               (rst),
    .stall             (stall),
    .ex_to_mem_bus     (ex_to_mem_bus),
    .data_sram_rdata   (data_sram_rdata),
    .data_sram_rvalid  (data_sram_rvalid),
    .mem_to_wb_bus     (mem_to_wb_bus),
    .mem_to_id         (mem_to_id),
    .stallreq_from_mem (stallreq_from_mem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [78:0] mk_bus(input logic [31:0] pc, input logic [2:0] op,
                                         input logic en, input logic [3:0] wen,
                                         input logic sel, input logic we,
                                         input logic [4:0] waddr, input logic [31:0] res);
    return {pc, op, en, wen, sel, we, waddr, res};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  initial begin
    logic [31:0] pc;
    checks = 0;
    errors = 0;

    vecs[0]  = '{1'b1, 4'hF, 3'b000, 1'b0, 1'b0, 5'd0, 32'h0000_2000, 32'h0, 1'b0, 32'h0000_2000, 1'b0};
    vecs[1]  = '{1'b0, 4'h0, 3'b000, 1'b0, 1'b1, 5'd3, 32'h1234_5678, 32'h0, 1'b0, 32'h1234_5678, 1'b0};
    vecs[2]  = '{1'b1, 4'h0, 3'b101, 1'b1, 1'b1, 5'd8, 32'h0000_1000, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 1'b0};
    vecs[3]  = '{1'b1, 4'h0, 3'b001, 1'b1, 1'b1, 5'd9, 32'h0000_1000, 32'h8081_F27F, 1'b1, 32'h0000_007F, 1'b0};
    vecs[4]  = '{1'b1, 4'h0, 3'b001, 1'b1, 1'b1, 5'd9, 32'h0000_1001, 32'h8081_F27F, 1'b1, 32'hFFFF_FFF2, 1'b0};
    vecs[5]  = '{1'b1, 4'h0, 3'b010, 1'b1, 1'b1, 5'd9, 32'h0000_1003, 32'h8081_F27F, 1'b1, 32'h0000_0080, 1'b0};
    vecs[6]  = '{1'b1, 4'h0, 3'b011, 1'b1, 1'b1, 5'd9, 32'h0000_1002, 32'h8081_F27F, 1'b1, 32'hFFFF_8081, 1'b0};
    vecs[7]  = '{1'b1, 4'h0, 3'b100, 1'b1, 1'b1, 5'd9, 32'h0000_1000, 32'h8081_F27F, 1'b1, 32'h0000_F27F, 1'b0};
    vecs[8]  = '{1'b1, 4'h0, 3'b011, 1'b1, 1'b1, 5'd9, 32'h0000_1001, 32'h8081_F27F, 1'b1, 32'hFFFF_F27F, 1'b0};
    vecs[9]  = '{1'b1, 4'h0, 3'b110, 1'b1, 1'b1, 5'd9, 32'h0000_1002, 32'h8081_F27F, 1'b1, 32'h8081_F27F, 1'b0};
    vecs[10] = '{1'b1, 4'h1, 3'b101, 1'b0, 1'b0, 5'd0, 32'h0000_3000, 32'h0, 1'b0, 32'h0000_3000, 1'b0};

    // Reset held two cycles with noisy inputs.
    rst = 1'b0;
    stall = 6'b000000;
    ex_to_mem_bus = mk_bus(32'hBFC0_0000, 3'b101, 1'b1, 4'h0, 1'b1, 1'b1, 5'd1, 32'h10);
    data_sram_rdata = 32'h1234_5678;
    data_sram_rvalid = 1'b1;
    tick();
    tick();
    chk("reset_wb", mem_to_wb_bus, 70'h0);
    chk("reset_id", {32'h0, mem_to_id}, 70'h0);
    chk("reset_stallreq", {69'h0, stallreq_from_mem}, 70'h0);
    rst = 1'b1;

    // Single-cycle accesses: response (if any) arrives on the first MEM cycle.
    for (int i = 0; i < 11; i++) begin
      pc = 32'h0040_0000 + 32'(i * 4);
      ex_to_mem_bus = mk_bus(pc, vecs[i].op, vecs[i].en, vecs[i].wen, vecs[i].sel,
                             vecs[i].we, vecs[i].waddr, vecs[i].addr);
      stall = 6'b000000;
      data_sram_rvalid = 1'b0;
      data_sram_rdata = 32'h0;
      tick();
      data_sram_rdata = vecs[i].rdata;
      data_sram_rvalid = vecs[i].rvalid;
      #1;
      chk($sformatf("vec%0d_stallreq", i), {69'h0, stallreq_from_mem}, {69'h0, vecs[i].exp_stallreq});
      chk($sformatf("vec%0d_wb", i), mem_to_wb_bus, {pc, vecs[i].we, vecs[i].waddr, vecs[i].exp_wdata});
      chk($sformatf("vec%0d_id", i), {32'h0, mem_to_id}, {32'h0, vecs[i].we, vecs[i].waddr, vecs[i].exp_wdata});
    end

    // Late response: three stall cycles, register holds the LW.
    ex_to_mem_bus = mk_bus(32'h0050_0000, 3'b101, 1'b1, 4'h0, 1'b1, 1'b1, 5'd9, 32'h0000_2000);
    stall = 6'b000000;
    data_sram_rvalid = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("late_stall%0d", k), {69'h0, stallreq_from_mem}, 70'h1);
      chk($sformatf("late_hold%0d", k), {38'h0, mem_to_wb_bus[69:38]}, {38'h0, 32'h0050_0000});
      stall = 6'b011111;
      ex_to_mem_bus = mk_bus(32'hFFFF_0000, 3'b000, 1'b0, 4'h0, 1'b0, 1'b1, 5'd31, 32'h77);
      tick();
    end
    data_sram_rdata = 32'h0BAD_F00D;
    data_sram_rvalid = 1'b1;
    stall = 6'b000000;
    #1;
    chk("late_done_stallreq", {69'h0, stallreq_from_mem}, 70'h0);
    chk("late_done_wb", mem_to_wb_bus, {32'h0050_0000, 1'b1, 5'd9, 32'h0BAD_F00D});

    // Downstream hold after data with a spurious response.
    ex_to_mem_bus = mk_bus(32'h0060_0000, 3'b101, 1'b1, 4'h0, 1'b1, 1'b1, 5'd10, 32'h0000_3004);
    tick();
    data_sram_rdata = 32'hCAFE_F00D;
    data_sram_rvalid = 1'b1;
    stall = 6'b011111;
    #1;
    chk("hold_first_wb", mem_to_wb_bus, {32'h0060_0000, 1'b1, 5'd10, 32'hCAFE_F00D});
    tick();
    data_sram_rdata = 32'h1111_1111;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk($sformatf("hold_wb%0d", k), mem_to_wb_bus, {32'h0060_0000, 1'b1, 5'd10, 32'hCAFE_F00D});
      chk($sformatf("hold_stallreq%0d", k), {69'h0, stallreq_from_mem}, 70'h0);
      tick();
    end

    // Bubble.
    data_sram_rvalid = 1'b0;
    stall = 6'b000000;
    ex_to_mem_bus = mk_bus(32'h0070_0000, 3'b000, 1'b0, 4'h0, 1'b0, 1'b1, 5'd4, 32'hA5A5_A5A5);
    tick();
    chk("alu_wb", mem_to_wb_bus, {32'h0070_0000, 1'b1, 5'd4, 32'hA5A5_A5A5});
    stall = 6'b001000;
    tick();
    chk("bubble_wb", mem_to_wb_bus, 70'h0);
    chk("bubble_id", {32'h0, mem_to_id}, 70'h0);

    // Reset while waiting; a later response is ignored.
    stall = 6'b000000;
    ex_to_mem_bus = mk_bus(32'h0080_0000, 3'b101, 1'b1, 4'h0, 1'b1, 1'b1, 5'd12, 32'h0000_4000);
    tick();
    chk("rstwait_stallreq", {69'h0, stallreq_from_mem}, 70'h1);
    stall = 6'b011111;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("rstwait_after_stallreq", {69'h0, stallreq_from_mem}, 70'h0);
    chk("rstwait_after_wb", mem_to_wb_bus, 70'h0);
    data_sram_rdata = 32'h5555_5555;
    data_sram_rvalid = 1'b1;
    #1;
    chk("rstwait_rvalid_wb", mem_to_wb_bus, 70'h0);
    chk("rstwait_rvalid_stallreq", {69'h0, stallreq_from_mem}, 70'h0);
    tick();
    data_sram_rvalid = 1'b0;
    chk("rstwait_late_wb", mem_to_wb_bus, 70'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
